// File: rtl/sysref_qualifier_if.sv
// sysref_qualifier_if: SYSREF input, configuration/control and qualified outputs of the qualifier
interface sysref_qualifier_if #(parameter int PERIOD_W = 16) ();
  logic                sysref_i;
  logic [PERIOD_W-1:0] exp_period;
  logic                arm;
  logic                disarm;
  logic                oneshot;
  logic                err_clr;
  logic                sysref_gated_o;
  logic                lmfc_o;
  logic                locked_o;
  logic [PERIOD_W-1:0] period_o;
  logic [2:0]          err_o;
  modport slave (
    input  sysref_i, exp_period, arm, disarm, oneshot, err_clr,
    output sysref_gated_o, lmfc_o, locked_o, period_o, err_o
  );
  modport master (
    output sysref_i, exp_period, arm, disarm, oneshot, err_clr,
    input  sysref_gated_o, lmfc_o, locked_o, period_o, err_o
  );
endinterface

// File: rtl/sysref_qualifier.sv
// sysref_qualifier: locks onto a periodic SYSREF, gates qualified edges and regenerates an aligned LMFC pulse
module sysref_qualifier #(
  parameter int PERIOD_W = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1
) (
  input logic pl_refclk_m,
  input logic rstn,
  sysref_qualifier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKING, LOCKED} state_t;
  state_t              state_q, state_d;
  logic                sys_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, lcnt_q, lcnt_d, exp_q, exp_d, period_q, period_d, diff;
  logic [3:0]          match_q, match_d;
  logic                os_q, os_d, done_q, done_d, gated_q, gated_d, lmfc_q, lmfc_d;
  logic [2:0]          err_q, err_d, err_set;
  logic                edge_det, match, missing, lk_match, to_lock, reload;
  always_comb begin
    edge_det = bus.sysref_i & ~sys_q;
    cnt_d    = edge_det ? PERIOD_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    diff     = cnt_q >= exp_q ? cnt_q - exp_q : exp_q - cnt_q;
    match    = diff <= PERIOD_W'(TOL);
    missing  = !edge_det && ({1'b0, cnt_q} == {1'b0, exp_q} + (PERIOD_W+1)'(TOL + 1));
    state_d  = state_q;
    match_d  = match_q;
    exp_d    = exp_q;
    os_d     = os_q;
    done_d   = done_q;
    err_set  = '0;
    if (bus.disarm) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (bus.arm && bus.exp_period < PERIOD_W'(2)) err_set[2] = 1'b1;
      else if (bus.arm) begin
        state_d = ARMED;
        exp_d   = bus.exp_period;
        os_d    = bus.oneshot;
        done_d  = 1'b0;
      end
    end else if (state_q == ARMED) begin
      if (edge_det) begin
        state_d = LOCKING;
        match_d = '0;
      end
    end else if (edge_det && !match) begin
      err_set[0] = 1'b1;
      match_d    = '0;
      state_d    = LOCKING;
    end else if (edge_det && state_q == LOCKING) begin
      match_d = match_q + 4'd1;
      state_d = (match_q + 4'd1 == 4'(LOCK_CNT)) ? LOCKED : LOCKING;
    end else if (missing) begin
      err_set[1] = 1'b1;
      match_d    = '0;
      state_d    = LOCKING;
    end
    // the LMFC phase is re-anchored on the lock-entry edge and on every matching edge
    lk_match = state_q == LOCKED && edge_det && match;
    to_lock  = state_d == LOCKED;
    reload   = (to_lock && state_q == LOCKING) || lk_match || lcnt_q == exp_q;
    lcnt_d   = to_lock ? (reload ? PERIOD_W'(1) : lcnt_q + 1'b1) : '0;
    lmfc_d   = to_lock && reload;
    gated_d  = to_lock && lk_match && !(os_q && done_q);
    done_d   = done_d | (gated_d & os_q);
    period_d = edge_det ? cnt_q : period_q;
    err_d    = (bus.err_clr ? 3'b000 : err_q) | err_set;
  end
  always_ff @(posedge pl_refclk_m) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sys_q    <= 1'b0;
      cnt_q    <= '0;
      lcnt_q   <= '0;
      exp_q    <= '0;
      period_q <= '0;
      match_q  <= '0;
      os_q     <= 1'b0;
      done_q   <= 1'b0;
      gated_q  <= 1'b0;
      lmfc_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      sys_q    <= bus.sysref_i;
      cnt_q    <= cnt_d;
      lcnt_q   <= lcnt_d;
      exp_q    <= exp_d;
      period_q <= period_d;
      match_q  <= match_d;
      os_q     <= os_d;
      done_q   <= done_d;
      gated_q  <= gated_d;
      lmfc_q   <= lmfc_d;
      err_q    <= err_d;
    end
  end
  assign bus.sysref_gated_o = gated_q;
  assign bus.lmfc_o         = lmfc_q;
  assign bus.locked_o       = state_q == LOCKED;
  assign bus.period_o       = period_q;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_sysref_qualifier.sv
// tb_sysref_qualifier: directed SYSREF trains with a pulse scoreboard plus status checks
module tb_sysref_qualifier;
  typedef struct {int cyc; logic g; logic l;} ev_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   errs = 0;
  ev_t  sb[$];
  int   s;
  sysref_qualifier_if #(.PERIOD_W(16)) bus ();
  sysref_qualifier #(.PERIOD_W(16), .LOCK_CNT(4), .TOL(1)) dut (
    .pl_refclk_m(clk),
    .rstn(rstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.sysref_gated_o || bus.lmfc_o) begin
      vectors++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL pulse: unexpected gated=%0b lmfc=%0b at cycle %0d", bus.sysref_gated_o, bus.lmfc_o, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.g != bus.sysref_gated_o || e.l != bus.lmfc_o) begin
          errs++;
          $display("FAIL pulse: got cycle %0d gated=%0b lmfc=%0b, expected cycle %0d gated=%0b lmfc=%0b",
                   cyc, bus.sysref_gated_o, bus.lmfc_o, e.cyc, e.g, e.l);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic push(input int c, input logic g, input logic l);
    sb.push_back('{c, g, l});
  endtask
  task automatic pulse_edge();
    bus.sysref_i = 1'b1;
    tick();
    bus.sysref_i = 1'b0;
  endtask
  task automatic train(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      if (i > 0) wait_n(p - 1);
      pulse_edge();
    end
  endtask
  task automatic do_arm(input int e, input logic os);
    bus.exp_period = 16'(e);
    bus.oneshot = os;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask
  task automatic pulse_disarm();
    bus.disarm = 1'b1;
    tick();
    bus.disarm = 1'b0;
  endtask
  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask
  initial begin
    int gaps[11] = '{10, 10, 10, 10, 10, 12, 10, 10, 10, 10, 11};
    bus.sysref_i = 1'b0;
    bus.exp_period = '0;
    bus.arm = 1'b0;
    bus.disarm = 1'b0;
    bus.oneshot = 1'b0;
    bus.err_clr = 1'b0;
    wait_n(3);
    rstn = 1'b1;
    tick();
    chk("rst_locked", 32'(bus.locked_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_period", 32'(bus.period_o), 0);
    chk("rst_pulses", {bus.sysref_gated_o, bus.lmfc_o}, 0);
    // continuous mode, then edges stop
    do_arm(10, 1'b0);
    wait_n(3);
    s = cyc + 1;
    push(s + 40, 0, 1);
    push(s + 50, 1, 1);
    push(s + 60, 1, 1);
    push(s + 70, 1, 1);
    push(s + 80, 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) wait_n(9);
      pulse_edge();
      if (i == 3) chk("pre_lock", 32'(bus.locked_o), 0);
      if (i == 4) chk("lock", 32'(bus.locked_o), 1);
      if (i == 5) chk("period10", 32'(bus.period_o), 10);
      if (i == 5) chk("err_locked", 32'(bus.err_o), 0);
    end
    wait_until(s + 81);
    chk("still_locked", 32'(bus.locked_o), 1);
    wait_until(s + 82);
    chk("miss_unlock", 32'(bus.locked_o), 0);
    chk("miss_err", 32'(bus.err_o), 3'b010);
    wait_n(15);
    pulse_clr();
    chk("err_clr", 32'(bus.err_o), 0);
    pulse_disarm();
    chk("drain1", sb.size(), 0);
    // oneshot mode
    do_arm(10, 1'b1);
    wait_n(3);
    s = cyc + 1;
    push(s + 40, 0, 1);
    push(s + 50, 1, 1);
    push(s + 60, 0, 1);
    push(s + 70, 0, 1);
    train(7, 10);
    wait_until(s + 72);
    chk("os_unlock", 32'(bus.locked_o), 0);
    wait_n(5);
    pulse_disarm();
    pulse_clr();
    chk("drain2", sb.size(), 0);
    // one long period, relock, tolerant period
    do_arm(10, 1'b0);
    wait_n(3);
    s = cyc + 1;
    push(s + 40, 0, 1);
    push(s + 50, 1, 1);
    push(s + 60, 0, 1);
    push(s + 102, 0, 1);
    push(s + 112, 0, 1);
    push(s + 113, 1, 1);
    push(s + 123, 0, 1);
    pulse_edge();
    for (int i = 0; i < 11; i++) begin
      wait_n(gaps[i] - 1);
      pulse_edge();
      if (i == 5) chk("mm_unlock", 32'(bus.locked_o), 0);
      if (i == 5) chk("mm_err", 32'(bus.err_o), 3'b001);
      if (i == 9) chk("relock", 32'(bus.locked_o), 1);
      if (i == 10) chk("tol_err", 32'(bus.err_o), 3'b001);
      if (i == 10) chk("period11", 32'(bus.period_o), 11);
    end
    wait_until(s + 125);
    chk("mm_miss_err", 32'(bus.err_o), 3'b011);
    pulse_clr();
    chk("err_clr2", 32'(bus.err_o), 0);
    pulse_disarm();
    chk("drain3", sb.size(), 0);
    // bad configuration, arm with disarm
    do_arm(1, 1'b0);
    chk("cfg_err", 32'(bus.err_o), 3'b100);
    train(6, 10);
    chk("cfg_idle", 32'(bus.locked_o), 0);
    pulse_clr();
    bus.exp_period = 16'd10;
    bus.arm = 1'b1;
    bus.disarm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.disarm = 1'b0;
    train(6, 10);
    wait_n(20);
    chk("armdis_idle", 32'(bus.locked_o), 0);
    chk("armdis_err", 32'(bus.err_o), 0);
    chk("drain4", sb.size(), 0);
    // reset while locked, mid-LMFC
    do_arm(10, 1'b0);
    wait_n(3);
    s = cyc + 1;
    push(s + 40, 0, 1);
    push(s + 50, 1, 1);
    train(6, 10);
    wait_until(s + 54);
    rstn = 1'b0;
    tick();
    chk("rst2_locked", 32'(bus.locked_o), 0);
    chk("rst2_pulses", {bus.sysref_gated_o, bus.lmfc_o}, 0);
    chk("rst2_period", 32'(bus.period_o), 0);
    chk("rst2_err", 32'(bus.err_o), 0);
    rstn = 1'b1;
    wait_n(4);
    train(6, 10);
    wait_n(20);
    chk("post_rst_idle", 32'(bus.locked_o), 0);
    chk("drain5", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
